pkt_chan_merger: RTL



---
 rtl/pkt_chan_merger.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/pkt_chan_merger.sv
// pkt_chan_merger
//   Merges NUM_CHANNELS per-channel valid/ready packet streams from the packet
//   router into one stream for the HSSL frame assembler. Each output packet is
//   tagged with the channel it arrived on.
//
//   Each channel has a one-entry holding buffer. A round-robin arbiter loads a
//   single registered output stage, so no channel can starve another.
//
// Ports
//   clk               clock
//   reset             asynchronous, active-high reset
//   pkt_in_data_in    per-channel packet (unpacked array)
//   pkt_in_vld_in     per-channel valid
//   pkt_in_rdy_out    per-channel ready (registered: !full, low during reset)
//   pkt_out_data_out  merged packet
//   pkt_out_chan_out  channel tag of the merged packet
//   pkt_out_vld_out   merged valid
//   pkt_out_rdy_in    downstream ready
//   pkt_cnt_out       per-channel output transfer count (only with
//                     PKT_CHAN_MERGER_CNT_EN defined)
//
// Configuration macros
//   PKT_BITS                default packet width (48 if undefined)
//   NUM_CHANS               default channel count (8 if undefined)
//   PKT_CHAN_MERGER_CNT_EN  adds the per-channel output transfer counters

`ifndef PKT_BITS
`define PKT_BITS 48
`endif
`ifndef NUM_CHANS
`define NUM_CHANS 8
`endif

module pkt_chan_merger #(
  parameter int PACKET_BITS  = `PKT_BITS,
  parameter int NUM_CHANNELS = `NUM_CHANS,
  parameter int CHAN_BITS    = $clog2(NUM_CHANNELS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [PACKET_BITS-1:0]  pkt_in_data_in [NUM_CHANNELS],
  input  logic [NUM_CHANNELS-1:0] pkt_in_vld_in,
  output logic [NUM_CHANNELS-1:0] pkt_in_rdy_out,
  output logic [PACKET_BITS-1:0]  pkt_out_data_out,
  output logic [CHAN_BITS-1:0]    pkt_out_chan_out,
  output logic                    pkt_out_vld_out,
  input  logic                    pkt_out_rdy_in
`ifdef PKT_CHAN_MERGER_CNT_EN
  ,
  output logic [31:0]             pkt_cnt_out [NUM_CHANNELS]
`endif
);

  logic [PACKET_BITS-1:0]  buf_data [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] full;
  logic [CHAN_BITS-1:0]    last;
  logic                    active;   // low in reset, high from the first edge after release

  logic                    load;
  logic [CHAN_BITS-1:0]    grant;
  logic                    grant_vld;
  logic [NUM_CHANNELS-1:0] accept;
  logic [NUM_CHANNELS-1:0] clr_mask;

  // Ready depends only on registered state: no path from pkt_out_rdy_in.
  assign pkt_in_rdy_out = ~full & {NUM_CHANNELS{active}};
  assign accept         = pkt_in_vld_in & pkt_in_rdy_out;

  // The output stage may load when empty or when it drains this cycle.
  assign load = !pkt_out_vld_out || pkt_out_rdy_in;

  // Round-robin search from last+1 upward with wrap. Offsets are visited from
  // the farthest to the nearest so the nearest full channel is written last
  // and wins; offset NUM_CHANNELS wraps to last itself (lowest priority).
  always_comb begin
    // NOTE: every variable gets a default before any conditional write so
    // that no path leaves it unassigned, which would infer a latch.
    grant     = last;
    grant_vld = 1'b0;
    for (int i = NUM_CHANNELS; i >= 1; i--) begin
      if (full[last + CHAN_BITS'(i)]) begin
        grant     = last + CHAN_BITS'(i);
        grant_vld = 1'b1;
      end
    end
  end

  assign clr_mask = (load && grant_vld) ? (NUM_CHANNELS'(1) << grant) : '0;

  // A granted buffer had rdy low this cycle, so it cannot be refilled at the
  // same edge; clear and set never collide on one channel.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      full             <= '0;
      last             <= CHAN_BITS'(NUM_CHANNELS - 1);
      active           <= 1'b0;
      pkt_out_vld_out  <= 1'b0;
      pkt_out_data_out <= '0;
      pkt_out_chan_out <= '0;
    end else begin
      active <= 1'b1;
      full   <= (full & ~clr_mask) | accept;
      if (load) begin
        pkt_out_vld_out <= grant_vld;
        if (grant_vld) begin
          pkt_out_data_out <= buf_data[grant];
          pkt_out_chan_out <= grant;
          last             <= grant;
        end
      end
    end
  end

  // NOTE: the holding buffers carry no reset; their contents are never used
  // unless the matching full bit is set, which does reset.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (accept[c]) buf_data[c] <= pkt_in_data_in[c];
    end
  end

`ifdef PKT_CHAN_MERGER_CNT_EN
  logic [31:0] cnt [NUM_CHANNELS];

  // Counts wrap naturally at 32 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) cnt[c] <= '0;
    end else if (pkt_out_vld_out && pkt_out_rdy_in) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (pkt_out_chan_out == CHAN_BITS'(c)) cnt[c] <= cnt[c] + 32'd1;
      end
    end
  end

  assign pkt_cnt_out = cnt;
`endif

endmodule
